// File: rtl/mc_ctrl_fsm_ext_if.sv
// Control bundle between the multicycle MIPS controller and its datapath/memory port.
// master = controller side, slave = datapath side.
interface mc_ctrl_fsm_ext_if;
   logic [5:0] op;
   logic [5:0] func;
   logic       Zero;
   logic       mem_ready;

   logic       PCWrite;
   logic       PCWriteCond;
   logic       BranchNe;
   logic       pc_en;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic [1:0] MemtoReg;
   logic [1:0] RegDst;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       ExtOp;
   logic [2:0] ALUOp;
   logic [1:0] PCSrc;
   logic       illegal_op;
   logic       bus_err;
   logic [3:0] state_dbg;

   modport master (
      input  op, func, Zero, mem_ready,
      output PCWrite, PCWriteCond, BranchNe, pc_en, IorD, MemRead, MemWrite,
             IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ExtOp,
             ALUOp, PCSrc, illegal_op, bus_err, state_dbg
   );

   modport slave (
      output op, func, Zero, mem_ready,
      input  PCWrite, PCWriteCond, BranchNe, pc_en, IorD, MemRead, MemWrite,
             IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ExtOp,
             ALUOp, PCSrc, illegal_op, bus_err, state_dbg
   );
endinterface

// File: rtl/mc_ctrl_fsm_ext.sv
// Multicycle MIPS control FSM with bne/I-type ALU ops, memory wait/timeout and bus error.
// Define MC_JAL_JR_EN to decode jal/jr into dedicated JAL/JR states.
module mc_ctrl_fsm_ext #(
   parameter int unsigned WAIT_MAX = 15,
   parameter int unsigned WAIT_W   = 4
) (
   input logic               clk,
   input logic               nrst,
   mc_ctrl_fsm_ext_if.master bus
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_I_EXEC    = 4'd10,
      S_I_WB      = 4'd11
`ifdef MC_JAL_JR_EN
      ,
      S_JAL       = 4'd12,
      S_JR        = 4'd13
`endif
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
`ifdef MC_JAL_JR_EN
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] FN_JR   = 6'b001000;
`endif

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] mem_to_reg;
      logic [1:0] reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       ext_op;
      logic [2:0] alu_op;
      logic [1:0] pc_src;
   } ctl_t;

   // Moore control word for a state; op only matters for BRANCH and I_EXEC,
   // and is stable in the IR while those states are entered.
   function automatic ctl_t f_decode(input state_t s, input logic [5:0] opc);
      ctl_t c;
      c = '0;
      case (s)
         S_DECODE: begin
            c.alu_src_b = 2'b11;
            c.ext_op    = 1'b1;
         end
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            c.ext_op    = 1'b1;
         end
         S_MEM_READ: begin
            c.iord     = 1'b1;
            c.mem_read = 1'b1;
         end
         S_MEM_WB: begin
            c.mem_to_reg = 2'b01;
            c.reg_write  = 1'b1;
         end
         S_MEM_WRITE: begin
            c.iord      = 1'b1;
            c.mem_write = 1'b1;
         end
         S_R_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 3'b010;
         end
         S_R_WB: begin
            c.reg_dst   = 2'b01;
            c.reg_write = 1'b1;
         end
         S_I_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            case (opc)
               OP_SLTI: begin
                  c.ext_op = 1'b1;
                  c.alu_op = 3'b101;
               end
               OP_ANDI: c.alu_op = 3'b011;
               OP_ORI:  c.alu_op = 3'b100;
               default: c.ext_op = 1'b1;
            endcase
         end
         S_I_WB: c.reg_write = 1'b1;
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = 3'b001;
            c.pc_write_cond = 1'b1;
            c.pc_src        = 2'b01;
            c.branch_ne     = (opc == OP_BNE);
         end
         S_JUMP: begin
            c.pc_write = 1'b1;
            c.pc_src   = 2'b10;
         end
`ifdef MC_JAL_JR_EN
         S_JAL: begin
            c.pc_write   = 1'b1;
            c.pc_src     = 2'b10;
            c.reg_dst    = 2'b10;
            c.mem_to_reg = 2'b10;
            c.reg_write  = 1'b1;
         end
         S_JR: begin
            c.alu_src_a = 1'b1;
            c.pc_write  = 1'b1;
            c.pc_src    = 2'b11;
         end
`endif
         default: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'b01;
         end
      endcase
      return c;
   endfunction

   state_t              r_state;
   logic [WAIT_W-1:0]   r_wait_cnt;
   logic                r_bus_err;
   ctl_t                r_ctl;

   state_t              w_next;
   logic                w_timeout;
   logic                w_illegal;
   logic                w_wait_lim;
   logic                w_waiting;
   logic                w_fetch_ack;
   logic                w_pc_write;

   assign w_wait_lim = (r_wait_cnt == WAIT_W'(WAIT_MAX));

   always_comb begin
      w_next    = S_FETCH;
      w_timeout = 1'b0;
      w_illegal = 1'b0;
      w_waiting = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (bus.mem_ready) begin
               w_next = S_DECODE;
            end else begin
               w_waiting = 1'b1;
               w_timeout = w_wait_lim;
            end
         end
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW:                      w_next = S_MEM_ADDR;
`ifdef MC_JAL_JR_EN
               OP_R:    w_next = (bus.func == FN_JR) ? S_JR : S_R_EXEC;
               OP_JAL:  w_next = S_JAL;
`else
               OP_R:    w_next = S_R_EXEC;
`endif
               OP_BEQ, OP_BNE:                    w_next = S_BRANCH;
               OP_J:                              w_next = S_JUMP;
               OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: w_next = S_I_EXEC;
               default:                           w_illegal = 1'b1;
            endcase
         end
         S_MEM_ADDR: w_next = (bus.op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ: begin
            if (bus.mem_ready) begin
               w_next = S_MEM_WB;
            end else begin
               w_waiting = 1'b1;
               w_timeout = w_wait_lim;
               w_next    = w_wait_lim ? S_FETCH : S_MEM_READ;
            end
         end
         S_MEM_WRITE: begin
            if (!bus.mem_ready) begin
               w_waiting = 1'b1;
               w_timeout = w_wait_lim;
               w_next    = w_wait_lim ? S_FETCH : S_MEM_WRITE;
            end
         end
         S_R_EXEC: w_next = S_R_WB;
         S_I_EXEC: w_next = S_I_WB;
         default:  w_next = S_FETCH;
      endcase
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state    <= S_FETCH;
         r_wait_cnt <= '0;
         r_bus_err  <= 1'b0;
         r_ctl      <= f_decode(S_FETCH, '0);
      end else begin
         r_state <= w_next;
         r_ctl   <= f_decode(w_next, bus.op);
         if (w_timeout) begin
            r_bus_err <= 1'b1;
         end
         if (w_timeout || (w_next != r_state)) begin
            r_wait_cnt <= '0;
         end else if (w_waiting) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
         end
      end
   end

   // Fetch write enables follow mem_ready directly and are held off during reset.
   assign w_fetch_ack = (r_state == S_FETCH) && bus.mem_ready && nrst;
   assign w_pc_write  = r_ctl.pc_write | w_fetch_ack;

   assign bus.PCWrite     = w_pc_write;
   assign bus.IRWrite     = w_fetch_ack;
   assign bus.PCWriteCond = r_ctl.pc_write_cond;
   assign bus.BranchNe    = r_ctl.branch_ne;
   assign bus.pc_en       = w_pc_write | (r_ctl.pc_write_cond & (bus.Zero ^ r_ctl.branch_ne));
   assign bus.IorD        = r_ctl.iord;
   assign bus.MemRead     = r_ctl.mem_read;
   assign bus.MemWrite    = r_ctl.mem_write;
   assign bus.MemtoReg    = r_ctl.mem_to_reg;
   assign bus.RegDst      = r_ctl.reg_dst;
   assign bus.RegWrite    = r_ctl.reg_write;
   assign bus.ALUSrcA     = r_ctl.alu_src_a;
   assign bus.ALUSrcB     = r_ctl.alu_src_b;
   assign bus.ExtOp       = r_ctl.ext_op;
   assign bus.ALUOp       = r_ctl.alu_op;
   assign bus.PCSrc       = r_ctl.pc_src;
   assign bus.illegal_op  = w_illegal;
   assign bus.bus_err     = r_bus_err;
   assign bus.state_dbg   = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm_ext.sv
// Bench for mc_ctrl_fsm_ext: instruction-level model builds the expected state/output
// sequence per instruction; a negedge compare process checks every cycle.
module tb_mc_ctrl_fsm_ext;
   localparam int WM = 3;

   localparam logic [5:0] OPC_R    = 6'b000000;
   localparam logic [5:0] OPC_LW   = 6'b100011;
   localparam logic [5:0] OPC_SW   = 6'b101011;
   localparam logic [5:0] OPC_BEQ  = 6'b000100;
   localparam logic [5:0] OPC_BNE  = 6'b000101;
   localparam logic [5:0] OPC_J    = 6'b000010;
   localparam logic [5:0] OPC_JAL  = 6'b000011;
   localparam logic [5:0] OPC_ADDI = 6'b001000;
   localparam logic [5:0] OPC_SLTI = 6'b001010;
   localparam logic [5:0] OPC_ANDI = 6'b001100;
   localparam logic [5:0] OPC_ORI  = 6'b001101;

`ifdef MC_JAL_JR_EN
   localparam bit JALJR = 1'b1;
`else
   localparam bit JALJR = 1'b0;
`endif

   typedef struct packed {
      logic pcw, pcwc, bne, pcen, iord, mrd, mwr, irw;
      logic [1:0] m2r, rdst;
      logic rw, asa;
      logic [1:0] asb;
      logic ext;
      logic [2:0] aop;
      logic [1:0] psrc;
      logic ill, berr;
   } ov_t;

   typedef struct {
      int   st;
      logic mr;
      logic be;
   } step_t;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   mc_ctrl_fsm_ext_if bus ();

   mc_ctrl_fsm_ext #(.WAIT_MAX(WM), .WAIT_W(4)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   int    n_tests = 0;
   int    n_fail  = 0;
   step_t q[$];
   int    hist[$];
   logic  m_berr = 1'b0;
   bit    exp_valid = 1'b0;
   int    exp_st;
   ov_t   exp_ov;
   ov_t   act_ov;
   int    irw_cnt, rw_cnt, mw_cnt, ill_cnt;
   logic  br_pce;
   logic [3:0] iexec;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic bit legal(input logic [5:0] opc);
      case (opc)
         OPC_R, OPC_LW, OPC_SW, OPC_BEQ, OPC_BNE, OPC_J,
         OPC_ADDI, OPC_SLTI, OPC_ANDI, OPC_ORI: return 1'b1;
         OPC_JAL: return JALJR;
         default: return 1'b0;
      endcase
   endfunction

   // Expected outputs for a state number, straight from the per-state output table.
   function automatic ov_t model_out(input int st, input logic [5:0] opc, input logic mr,
                                     input logic z, input logic be);
      ov_t o;
      o = '0;
      case (st)
         0:  begin o.mrd = 1; o.asb = 2'b01; o.irw = mr; o.pcw = mr; end
         1:  begin o.asb = 2'b11; o.ext = 1; o.ill = !legal(opc); end
         2:  begin o.asa = 1; o.asb = 2'b10; o.ext = 1; end
         3:  begin o.iord = 1; o.mrd = 1; end
         4:  begin o.m2r = 2'b01; o.rw = 1; end
         5:  begin o.iord = 1; o.mwr = 1; end
         6:  begin o.asa = 1; o.aop = 3'b010; end
         7:  begin o.rdst = 2'b01; o.rw = 1; end
         8:  begin o.asa = 1; o.aop = 3'b001; o.pcwc = 1; o.psrc = 2'b01; o.bne = (opc == OPC_BNE); end
         9:  begin o.pcw = 1; o.psrc = 2'b10; end
         10: begin
            o.asa = 1; o.asb = 2'b10;
            o.ext = (opc == OPC_ADDI) || (opc == OPC_SLTI);
            o.aop = (opc == OPC_SLTI) ? 3'b101 : (opc == OPC_ANDI) ? 3'b011 :
                    (opc == OPC_ORI) ? 3'b100 : 3'b000;
         end
         11: o.rw = 1;
         12: begin o.pcw = 1; o.psrc = 2'b10; o.rdst = 2'b10; o.m2r = 2'b10; o.rw = 1; end
         13: begin o.asa = 1; o.pcw = 1; o.psrc = 2'b11; end
         default: o = '0;
      endcase
      o.pcen = o.pcw | (o.pcwc & (z ^ o.bne));
      o.berr = be;
      return o;
   endfunction

   task automatic push(input int st, input logic mr);
      q.push_back('{st, mr, m_berr});
   endtask

   // w low cycles then a ready cycle; every WM+1 consecutive low cycles is a timeout.
   task automatic add_wait(input int st, input int w, output bit aborted);
      aborted = 1'b0;
      for (int k = 1; k <= w; k++) begin
         push(st, 1'b0);
         if (k % (WM + 1) == 0) begin
            m_berr = 1'b1;
            if (st != 0) begin
               aborted = 1'b1;
               return;
            end
         end
      end
      push(st, 1'b1);
   endtask

   task automatic build(input logic [5:0] opc, input logic [5:0] fn, input int fw, input int mw);
      bit ab;
      q.delete();
      add_wait(0, fw, ab);
      push(1, 1'b1);
      if (!legal(opc)) return;
      case (opc)
         OPC_LW: begin
            push(2, 1'b1);
            add_wait(3, mw, ab);
            if (!ab) push(4, 1'b1);
         end
         OPC_SW: begin
            push(2, 1'b1);
            add_wait(5, mw, ab);
         end
         OPC_R: begin
            if (JALJR && fn == 6'b001000) push(13, 1'b1);
            else begin push(6, 1'b1); push(7, 1'b1); end
         end
         OPC_BEQ, OPC_BNE: push(8, 1'b1);
         OPC_J:   push(9, 1'b1);
         OPC_JAL: push(12, 1'b1);
         default: begin push(10, 1'b1); push(11, 1'b1); end
      endcase
   endtask

   task automatic run(input logic [5:0] opc, input logic [5:0] fn, input logic z,
                      input int fw, input int mw, input int limit);
      build(opc, fn, fw, mw);
      hist.delete();
      irw_cnt = 0; rw_cnt = 0; mw_cnt = 0; ill_cnt = 0;
      br_pce = 1'bx; iexec = 4'bx;
      for (int i = 0; i < q.size() && (limit < 0 || i < limit); i++) begin
         bus.op = opc; bus.func = fn; bus.Zero = z;
         bus.mem_ready = q[i].mr;
         exp_st = q[i].st;
         exp_ov = model_out(q[i].st, opc, q[i].mr, z, q[i].be);
         exp_valid = 1'b1;
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [63:0] pack_hist();
      logic [63:0] h;
      h = '0;
      foreach (hist[i]) h = (h << 4) | 64'(hist[i]);
      return h;
   endfunction

   always @(negedge clk) begin
      if (exp_valid) begin
         act_ov = {bus.PCWrite, bus.PCWriteCond, bus.BranchNe, bus.pc_en, bus.IorD,
                   bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                   bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ExtOp, bus.ALUOp,
                   bus.PCSrc, bus.illegal_op, bus.bus_err};
         chk("state", 64'(bus.state_dbg), 64'(exp_st));
         chk("outputs", 64'(act_ov), 64'(exp_ov));
         hist.push_back(int'(bus.state_dbg) + 1);
         irw_cnt += int'(bus.IRWrite);
         rw_cnt  += int'(bus.RegWrite);
         mw_cnt  += int'(bus.MemWrite);
         ill_cnt += int'(bus.illegal_op);
         if (bus.state_dbg == 4'd8)  br_pce = bus.pc_en;
         if (bus.state_dbg == 4'd10) iexec  = {bus.ExtOp, bus.ALUOp};
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.op = '0; bus.func = '0; bus.Zero = 1'b0; bus.mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wen", 64'({bus.PCWrite, bus.IRWrite, bus.pc_en, bus.RegWrite, bus.MemWrite, bus.PCWriteCond}), 64'd0);
      chk("rst_fetch", 64'({bus.MemRead, bus.ALUSrcB, bus.IorD, bus.ALUSrcA, bus.ALUOp, bus.PCSrc}), 64'b1_01_0_0_000_00);
      chk("rst_state", 64'(bus.state_dbg), 64'd0);
      chk("rst_flags", 64'({bus.bus_err, bus.illegal_op}), 64'd0);
      nrst = 1'b1;

      run(OPC_LW, 6'd0, 1'b0, 2, 2, -1);
      chk("lw_states", pack_hist(), 64'h111234445);
      chk("lw_irw", 64'(irw_cnt), 64'd1);

      run(OPC_BEQ, 6'd0, 1'b1, 0, 0, -1);
      chk("beq_pcen", 64'(br_pce), 64'd1);
      chk("beq_ret", 64'(bus.state_dbg), 64'd0);
      run(OPC_BNE, 6'd0, 1'b1, 0, 0, -1);
      chk("bne_pcen", 64'(br_pce), 64'd0);
      chk("bne_ret", 64'(bus.state_dbg), 64'd0);
      run(OPC_BEQ, 6'd0, 1'b0, 0, 0, -1);
      run(OPC_BNE, 6'd0, 1'b0, 1, 0, -1);
      chk("bne_z0_pcen", 64'(br_pce), 64'd1);

      run(OPC_ANDI, 6'd0, 1'b0, 0, 0, -1);
      chk("andi_exec", 64'(iexec), 64'b0011);
      chk("andi_rw", 64'(rw_cnt), 64'd1);
      chk("andi_states", pack_hist(), 64'h12BC);
      run(OPC_ADDI, 6'd0, 1'b0, 0, 0, -1);
      run(OPC_SLTI, 6'd0, 1'b1, 0, 0, -1);
      run(OPC_ORI,  6'd0, 1'b0, 0, 0, -1);
      run(OPC_R, 6'b100000, 1'b0, 0, 0, -1);
      run(OPC_R, 6'b001000, 1'b0, 0, 0, -1);
      run(OPC_J, 6'd0, 1'b0, 0, 0, -1);

      run(6'b111111, 6'd0, 1'b0, 0, 0, -1);
      chk("ill_pulse", 64'(ill_cnt), 64'd1);
      chk("ill_nowr", 64'({rw_cnt[7:0], mw_cnt[7:0]}), 64'd0);
      chk("ill_ret", 64'(bus.state_dbg), 64'd0);

      run(OPC_LW, 6'd0, 1'b0, 0, WM, -1);
      chk("lw_edge_rw", 64'(rw_cnt), 64'd1);
      chk("lw_edge_berr", 64'(bus.bus_err), 64'd0);

      run(OPC_SW, 6'd0, 1'b0, 0, 10, -1);
      chk("sw_to_mw", 64'(mw_cnt), 64'd4);
      chk("sw_to_berr", 64'(bus.bus_err), 64'd1);
      chk("sw_to_ret", 64'(bus.state_dbg), 64'd0);
      run(OPC_SW, 6'd0, 1'b0, 0, 0, -1);
      run(OPC_R, 6'b100010, 1'b0, 0, 0, -1);

      run(OPC_JAL, 6'd0, 1'b0, 0, 0, -1);
      chk("jal_states", pack_hist(), JALJR ? 64'h12D : 64'h12);
      chk("jal_ill", 64'(ill_cnt), JALJR ? 64'd0 : 64'd1);

      run(OPC_LW, 6'd0, 1'b0, 0, 0, 3);
      exp_valid = 1'b0;
      bus.mem_ready = 1'b1;
      #2 nrst = 1'b0;
      #1;
      chk("mid_rst_state", 64'(bus.state_dbg), 64'd0);
      chk("mid_rst_wen", 64'({bus.RegWrite, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.IorD}), 64'd0);
      chk("mid_rst_berr", 64'(bus.bus_err), 64'd0);
      chk("mid_rst_mrd", 64'(bus.MemRead), 64'd1);
      m_berr = 1'b0;
      @(posedge clk);
      #1 nrst = 1'b1;

      run(OPC_LW, 6'd0, 1'b0, 5, 0, -1);
      chk("fetch_to_berr", 64'(bus.bus_err), 64'd1);
      chk("fetch_to_irw", 64'(irw_cnt), 64'd1);
      exp_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
